// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear; wrap flags the increment that returns to zero.
module mod_counter #(
    parameter int unsigned MOD = 4,
    localparam int unsigned W = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] Last = W'(MOD - 1);

    logic [W-1:0] count_q;

    assign count = count_q;
    assign wrap  = en && (count_q == Last);

    // Count up on en, return to zero after MOD-1; clear wins over enable.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= wrap ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/fir_decim_sequencer.sv
// Control sequencer for the polyphase FIR decimator: writes accepted samples into the
// delay-line RAMs and, every D samples, sweeps all taps driving RAM addresses and MAC strobes.
module fir_decim_sequencer #(
    parameter int unsigned MAC_SIZE = 255,
    parameter int unsigned D        = 100,
    parameter int unsigned MAC_NUM  = 1,
    localparam int unsigned AW      = $clog2(MAC_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          cfg_we,
    output logic          cfg_ready,
    output logic          sample_we,
    output logic          sample_en,
    output logic [AW-1:0] sample_addr,
    output logic          coeff_en,
    output logic [AW-1:0] coeff_addr,
    output logic          c_we,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          mac_done,
    output logic          busy
);

    localparam int unsigned PW = (D > 1) ? $clog2(D) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SWEEP = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [AW:0] MacSizeX = (AW + 1)'(MAC_SIZE);

    if (MAC_NUM < 1 || MAC_SIZE < 2 || D < 1) begin : g_bad_params
        $error("fir_decim_sequencer: MAC_NUM and D must be >= 1, MAC_SIZE >= 2");
    end

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] newest_q, newest_d;
    logic          mac_en_q, mac_clr_q;

    logic          in_idle, accept, issue;
    logic [AW-1:0] wr_ptr, tap;
    logic [PW-1:0] phase;
    logic          wr_wrap, phase_wrap, tap_wrap;
    logic [AW:0]   rd_diff, rd_full;

    assign in_idle = rst_n && (state_q == IDLE);
    // Coefficient writes take priority over samples in the same cycle.
    assign accept  = in_idle && s_valid && !cfg_we;
    assign issue   = rst_n && (state_q == SWEEP);

    mod_counter #(.MOD(MAC_SIZE)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .clr   (1'b0),
        .count (wr_ptr),
        .wrap  (wr_wrap)
    );

    mod_counter #(.MOD(D)) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .clr   (1'b0),
        .count (phase),
        .wrap  (phase_wrap)
    );

    mod_counter #(.MOD(MAC_SIZE)) u_tap (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (issue),
        .clr   (phase_wrap),
        .count (tap),
        .wrap  (tap_wrap)
    );

    // Read address walks backwards from the newest sample, wrapping modulo MAC_SIZE.
    always_comb begin
        rd_diff = {1'b0, newest_q} - {1'b0, tap};
        rd_full = rd_diff[AW] ? rd_diff + MacSizeX : rd_diff;
    end

    // Next-state: IDLE -> SWEEP on the D-th sample, then MAC_SIZE issues, drain, done.
    always_comb begin
        state_d  = state_q;
        newest_d = newest_q;
        unique case (state_q)
            IDLE: begin
                if (phase_wrap) begin
                    newest_d = wr_ptr;
                    state_d  = SWEEP;
                end
            end
            SWEEP:   if (tap_wrap) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and MAC strobe pipeline; strobes lag the issue by the RAM read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            newest_q  <= '0;
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            newest_q  <= newest_d;
            mac_en_q  <= issue;
            mac_clr_q <= issue && (tap == '0);
        end
    end

    // Outputs are forced low while reset is asserted.
    always_comb begin
        s_ready     = in_idle && !cfg_we;
        cfg_ready   = in_idle;
        c_we        = in_idle && cfg_we;
        coeff_en    = (in_idle && cfg_we) || issue;
        sample_we   = accept;
        sample_en   = accept || issue;
        sample_addr = '0;
        coeff_addr  = '0;
        if (issue) begin
            sample_addr = rd_full[AW-1:0];
            coeff_addr  = tap;
        end else if (in_idle) begin
            sample_addr = wr_ptr;
        end
        mac_en   = rst_n && mac_en_q;
        mac_clr  = rst_n && mac_clr_q;
        mac_done = rst_n && (state_q == DONE);
        busy     = rst_n && (state_q != IDLE);
    end

    logic unused_wr_wrap;
    assign unused_wr_wrap = wr_wrap ^ phase[0];

endmodule

// File: tb/tb_fir_decim_sequencer.sv
// Self-checking bench for fir_decim_sequencer with a small configuration (4 taps, decimate by 3).
module tb_fir_decim_sequencer;

    localparam int M  = 4;
    localparam int DD = 3;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          cfg_we = 1'b0;
    logic          s_ready, cfg_ready, sample_we, sample_en, coeff_en, c_we;
    logic          mac_clr, mac_en, mac_done, busy;
    logic [AW-1:0] sample_addr, coeff_addr;

    int vectors = 0;
    int errs    = 0;
    int mptr    = 0;  // model write pointer: accepted samples mod M
    int ph      = 0;  // model phase: accepted samples mod D

    fir_decim_sequencer #(
        .MAC_SIZE (M),
        .D        (DD),
        .MAC_NUM  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .cfg_we      (cfg_we),
        .cfg_ready   (cfg_ready),
        .sample_we   (sample_we),
        .sample_en   (sample_en),
        .sample_addr (sample_addr),
        .coeff_en    (coeff_en),
        .coeff_addr  (coeff_addr),
        .c_we        (c_we),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .mac_done    (mac_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b0;
            cfg_we  = 1'b0;
            @(negedge clk);
            chk1("idle_s_ready", s_ready, 1'b1);
            chk1("idle_busy", busy, 1'b0);
            chk1("idle_mac_en", mac_en, 1'b0);
            chk1("idle_mac_done", mac_done, 1'b0);
            chk1("idle_sample_we", sample_we, 1'b0);
            next_cycle();
        end
    endtask

    // One accepted sample; updates the model and reports whether it completes a decimation group.
    task automatic send_sample(output bit trig, output int newest);
        s_valid = 1'b1;
        cfg_we  = 1'b0;
        @(negedge clk);
        chk1("smp_s_ready", s_ready, 1'b1);
        chk1("smp_we", sample_we, 1'b1);
        chk1("smp_en", sample_en, 1'b1);
        chka("smp_addr", sample_addr, AW'(mptr));
        chk1("smp_busy", busy, 1'b0);
        chk1("smp_c_we", c_we, 1'b0);
        next_cycle();
        s_valid = 1'b0;
        newest  = mptr;
        mptr    = (mptr + 1) % M;
        ph      = (ph + 1) % DD;
        trig    = (ph == 0);
    endtask

    // Expected sweep: M issue cycles, drain, done; strobes delayed one cycle behind issue.
    task automatic check_sweep(input int newest);
        for (int k = 0; k < M + 2; k++) begin
            if (k == 0) begin
                s_valid = 1'b1;
                cfg_we  = 1'b1;
            end else if (k <= M) begin
                s_valid = 1'($urandom_range(0, 1));
                cfg_we  = 1'($urandom_range(0, 1));
            end else begin
                s_valid = 1'b0;
                cfg_we  = 1'b0;
            end
            @(negedge clk);
            chk1("sw_busy", busy, 1'b1);
            chk1("sw_s_ready", s_ready, 1'b0);
            chk1("sw_cfg_ready", cfg_ready, 1'b0);
            chk1("sw_c_we", c_we, 1'b0);
            chk1("sw_sample_we", sample_we, 1'b0);
            if (k < M) begin
                chk1("sw_sample_en", sample_en, 1'b1);
                chk1("sw_coeff_en", coeff_en, 1'b1);
                chka("sw_sample_addr", sample_addr, AW'((newest - k + M) % M));
                chka("sw_coeff_addr", coeff_addr, AW'(k));
            end
            chk1("sw_mac_en", mac_en, (k >= 1) && (k <= M));
            chk1("sw_mac_clr", mac_clr, k == 1);
            chk1("sw_mac_done", mac_done, k == M + 1);
            next_cycle();
        end
        @(negedge clk);
        chk1("post_s_ready", s_ready, 1'b1);
        chk1("post_cfg_ready", cfg_ready, 1'b1);
        chk1("post_busy", busy, 1'b0);
        chk1("post_mac_en", mac_en, 1'b0);
        chk1("post_mac_done", mac_done, 1'b0);
        next_cycle();
    endtask

    task automatic run_sample();
        bit trig;
        int newest;
        send_sample(trig, newest);
        if (trig) check_sweep(newest);
    endtask

    initial begin
        bit trig;
        int newest;

        // Reset held with inputs active: everything quiet.
        rst_n   = 1'b0;
        s_valid = 1'b1;
        cfg_we  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            chk1("rst_sample_we", sample_we, 1'b0);
            chk1("rst_sample_en", sample_en, 1'b0);
            chk1("rst_c_we", c_we, 1'b0);
            chk1("rst_coeff_en", coeff_en, 1'b0);
            chk1("rst_mac_en", mac_en, 1'b0);
            chk1("rst_mac_clr", mac_clr, 1'b0);
            chk1("rst_mac_done", mac_done, 1'b0);
            chk1("rst_busy", busy, 1'b0);
        end
        next_cycle();
        rst_n   = 1'b1;
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        @(negedge clk);
        chk1("rel_s_ready", s_ready, 1'b1);
        chk1("rel_cfg_ready", cfg_ready, 1'b1);
        chk1("rel_busy", busy, 1'b0);
        next_cycle();

        // Back-to-back samples, then a second group that wraps the write pointer.
        repeat (2 * DD) run_sample();

        // Coefficient write and sample in the same idle cycle.
        s_valid = 1'b1;
        cfg_we  = 1'b1;
        @(negedge clk);
        chk1("cfg_c_we", c_we, 1'b1);
        chk1("cfg_ready", cfg_ready, 1'b1);
        chk1("cfg_coeff_en", coeff_en, 1'b1);
        chk1("cfg_s_ready", s_ready, 1'b0);
        chk1("cfg_sample_we", sample_we, 1'b0);
        next_cycle();
        cfg_we = 1'b0;
        repeat (DD) run_sample();

        // Random gaps between samples; phase must hold across gaps.
        for (int r = 0; r < 2 * DD + 1; r++) begin
            idle_cycles(int'($urandom_range(0, 3)));
            run_sample();
        end

        // Finish the current group, then reset during the second sweep cycle.
        trig = 1'b0;
        while (!trig) send_sample(trig, newest);
        @(negedge clk);
        chk1("mid_busy", busy, 1'b1);
        chka("mid_sample_addr", sample_addr, AW'(newest));
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        chk1("mid_rst_busy", busy, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        mptr  = 0;
        ph    = 0;
        @(negedge clk);
        chk1("mid_post_s_ready", s_ready, 1'b1);
        chk1("mid_post_busy", busy, 1'b0);
        chk1("mid_post_mac_en", mac_en, 1'b0);
        chk1("mid_post_mac_done", mac_done, 1'b0);
        next_cycle();
        idle_cycles(4);
        repeat (DD) run_sample();
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
